fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the control unit.
- Holds the PC and issues 16-bit instruction reads over a req/rdy handshake.
- Drives the IF/ID register whose opcode and multiDiv fields feed the control decode.
- Handles stall, redirect on branch/jump, and halt (opcode 4'b0000).

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/fetch_skid_buf.sv | 56 +++++
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions: widths, instruction field positions,
//                opcodes and the fetch state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  // Instruction field slice positions
  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 12;
  localparam int FUNCT_HI  = 1;
  localparam int FUNCT_LO  = 0;

  // Opcodes seen by the control unit
  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_BNE   = 4'b0101;
  localparam logic [3:0] OP_JMP   = 4'b0110;
  localparam logic [3:0] OP_JAL   = 4'b0111;
  localparam logic [3:0] OP_TYPEA = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  // True when the opcode stops the fetch stage
  function automatic logic is_halt_op(input logic [3:0] op);
    return (op == OP_HALT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : One-entry holding buffer for an instruction that completes
//                while the IF/ID register is stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [ADDR_W-1:0]  load_pc_plus2,
  output logic               buf_valid,
  output logic [INSTR_W-1:0] buf_instr,
  output logic [ADDR_W-1:0]  buf_pc,
  output logic [ADDR_W-1:0]  buf_pc_plus2
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_pc_plus2;

  // Buffer entry: clear beats load, load beats drain (load+drain replaces)
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_pc_plus2 <= '0;
    end else if (load) begin
      r_valid    <= 1'b1;
      r_instr    <= load_instr;
      r_pc       <= load_pc;
      r_pc_plus2 <= load_pc_plus2;
    end else if (drain) begin
      r_valid    <= 1'b0;
    end
  end

  assign buf_valid    = r_valid;
  assign buf_instr    = r_instr;
  assign buf_pc       = r_pc;
  assign buf_pc_plus2 = r_pc_plus2;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Holds the PC, issues 16-bit reads
//                over a req/rdy handshake and drives the IF/ID register.
//                Supports stall (with one-entry skid), redirect and halt.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic               imemRdy,
  input  logic [INSTR_W-1:0] imemData,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirectPc,
  output logic               ifidValid,
  output logic [INSTR_W-1:0] ifidInstr,
  output logic [ADDR_W-1:0]  ifidPc,
  output logic [ADDR_W-1:0]  ifidPcPlus2,
  output logic [3:0]         opcode,
  output logic [1:0]         multiDiv,
  output logic               halted
);

  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] C_ALIGN   = ~ADDR_W'(1);

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_plus2;
  logic [ADDR_W-1:0]  w_redirect_target;
  logic               w_req;
  logic               w_done;
  logic               w_halt_word;

  logic               r_ifid_valid;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [ADDR_W-1:0]  r_ifid_pc;
  logic [ADDR_W-1:0]  r_ifid_pc_plus2;

  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [ADDR_W-1:0]  w_skid_pc;
  logic [ADDR_W-1:0]  w_skid_pc_plus2;
  logic               w_skid_load;
  logic               w_skid_drain;

  assign w_pc_plus2        = r_pc + C_PC_STEP;
  assign w_redirect_target = redirectPc & C_ALIGN;

  // A response arriving on a redirect edge belongs to the abandoned stream
  // and is dropped here rather than being tracked after the fact.
  assign w_done      = w_req & imemRdy & ~redirect;
  assign w_halt_word = is_halt_op(imemData[OPCODE_HI:OPCODE_LO]);

  // Park a completion in the skid when IF/ID cannot take it this edge
  assign w_skid_load  = w_done & (stall | w_skid_valid);
  assign w_skid_drain = w_skid_valid & ~stall & ~redirect;

  fetch_skid_buf #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) u_skid (
    .clk           (clk),
    .rst           (rst),
    .load          (w_skid_load),
    .drain         (w_skid_drain),
    .clear         (redirect),
    .load_instr    (imemData),
    .load_pc       (r_pc),
    .load_pc_plus2 (w_pc_plus2),
    .buf_valid     (w_skid_valid),
    .buf_instr     (w_skid_instr),
    .buf_pc        (w_skid_pc),
    .buf_pc_plus2  (w_skid_pc_plus2)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; redirect forces FETCH from any state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_req) begin
          if (w_done) begin
            w_state_next = w_halt_word ? ST_HALT : ST_FETCH;
          end else begin
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (w_done) begin
          w_state_next = w_halt_word ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
    if (redirect) begin
      w_state_next = ST_FETCH;
    end
  end

  // Outputs decoded from state; no request while in reset or skid is full
  always_comb begin
    w_req  = 1'b0;
    halted = 1'b0;
    case (r_state)
      ST_FETCH: w_req  = ~rst & ~w_skid_valid;
      ST_WAIT:  w_req  = ~rst;
      ST_HALT:  halted = 1'b1;
      default: begin
        w_req  = 1'b0;
        halted = 1'b0;
      end
    endcase
  end

  // Program counter: redirect target, or advance on a non-halt completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= w_redirect_target;
    end else if (w_done && !w_halt_word) begin
      r_pc <= w_pc_plus2;
    end
  end

  // IF/ID register: flush, hold, skid first, fresh completion, else bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_valid    <= 1'b0;
      r_ifid_instr    <= '0;
      r_ifid_pc       <= '0;
      r_ifid_pc_plus2 <= '0;
    end else if (redirect) begin
      r_ifid_valid    <= 1'b0;
    end else if (stall) begin
      r_ifid_valid    <= r_ifid_valid;
    end else if (w_skid_valid) begin
      r_ifid_valid    <= 1'b1;
      r_ifid_instr    <= w_skid_instr;
      r_ifid_pc       <= w_skid_pc;
      r_ifid_pc_plus2 <= w_skid_pc_plus2;
    end else if (w_done) begin
      r_ifid_valid    <= 1'b1;
      r_ifid_instr    <= imemData;
      r_ifid_pc       <= r_pc;
      r_ifid_pc_plus2 <= w_pc_plus2;
    end else begin
      r_ifid_valid    <= 1'b0;
    end
  end

  assign imemReq     = w_req;
  assign imemAddr    = r_pc;
  assign ifidValid   = r_ifid_valid;
  assign ifidInstr   = r_ifid_instr;
  assign ifidPc      = r_ifid_pc;
  assign ifidPcPlus2 = r_ifid_pc_plus2;
  assign opcode      = r_ifid_instr[OPCODE_HI:OPCODE_LO];
  assign multiDiv    = r_ifid_instr[FUNCT_HI:FUNCT_LO];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemRdy;
  logic [15:0] imemData;
  logic        stall;
  logic        redirect;
  logic [15:0] redirectPc;
  logic        ifidValid;
  logic [15:0] ifidInstr;
  logic [15:0] ifidPc;
  logic [15:0] ifidPcPlus2;
  logic [3:0]  opcode;
  logic [1:0]  multiDiv;
  logic        halted;

  int errors = 0;
  int checks = 0;

  // Memory model: fixed latency counted from the start of a request
  int   mem_lat   = 0;
  int   wait_cnt  = 0;
  logic force_rdy = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'hF001;
      16'h0002: return 16'h1123;
      16'h0004: return 16'h2456;
      16'h0010: return 16'h0000;
      default:  return 16'h1000 | {4'h0, a[11:0]};
    endcase
  endfunction

  assign imemData = mem_word(imemAddr);
  assign imemRdy  = force_rdy | (imemReq & (wait_cnt >= mem_lat));

  always_ff @(posedge clk) begin
    if (!imemReq || imemRdy) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemRdy     (imemRdy),
    .imemData    (imemData),
    .stall       (stall),
    .redirect    (redirect),
    .redirectPc  (redirectPc),
    .ifidValid   (ifidValid),
    .ifidInstr   (ifidInstr),
    .ifidPc      (ifidPc),
    .ifidPcPlus2 (ifidPcPlus2),
    .opcode      (opcode),
    .multiDiv    (multiDiv),
    .halted      (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b need 0", imemReq); end
    checks++; if (ifidValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", ifidValid); end
    checks++; if ({ifidInstr, ifidPc, ifidPcPlus2} !== 48'h0) begin errors++; $display("FAIL reset_ifid: got %h need 0", {ifidInstr, ifidPc, ifidPcPlus2}); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b need 0", halted); end
    rst = 1'b0;
    #1;
    checks++; if (imemReq !== 1'b1 || imemAddr !== 16'h0000) begin errors++; $display("FAIL first_req: got req=%b addr=%h need 1/0000", imemReq, imemAddr); end
  endtask

  task automatic test_zero_wait();
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidPc !== 16'h0000 || ifidInstr !== 16'hF001) begin errors++; $display("FAIL zw_first: got v=%b pc=%h instr=%h need 1/0000/F001", ifidValid, ifidPc, ifidInstr); end
    checks++; if (opcode !== 4'hF || multiDiv !== 2'b01) begin errors++; $display("FAIL zw_decode: got op=%h md=%b need F/01", opcode, multiDiv); end
    checks++; if (ifidPcPlus2 !== 16'h0002) begin errors++; $display("FAIL zw_plus2: got %h need 0002", ifidPcPlus2); end
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidPc !== 16'h0002 || ifidInstr !== 16'h1123) begin errors++; $display("FAIL zw_second: got v=%b pc=%h instr=%h need 1/0002/1123", ifidValid, ifidPc, ifidInstr); end
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidPc !== 16'h0004 || ifidInstr !== 16'h2456) begin errors++; $display("FAIL zw_third: got v=%b pc=%h instr=%h need 1/0004/2456", ifidValid, ifidPc, ifidInstr); end
  endtask

  task automatic test_wait_states();
    mem_lat = 3;
    #1;
    checks++; if (imemReq !== 1'b1 || imemAddr !== 16'h0006) begin errors++; $display("FAIL ws_addr0: got req=%b addr=%h need 1/0006", imemReq, imemAddr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ifidValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 16'h0006) begin errors++; $display("FAIL ws_hold%0d: got v=%b req=%b addr=%h need 0/1/0006", i, ifidValid, imemReq, imemAddr); end
    end
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidPc !== 16'h0006 || ifidInstr !== 16'h1006) begin errors++; $display("FAIL ws_done: got v=%b pc=%h instr=%h need 1/0006/1006", ifidValid, ifidPc, ifidInstr); end
    mem_lat = 0;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidPc !== 16'h0006 || imemReq !== 1'b0) begin errors++; $display("FAIL st_hold1: got v=%b pc=%h req=%b need 1/0006/0", ifidValid, ifidPc, imemReq); end
    tick();
    checks++; if (ifidPc !== 16'h0006 || ifidInstr !== 16'h1006 || imemReq !== 1'b0) begin errors++; $display("FAIL st_hold2: got pc=%h instr=%h req=%b need 0006/1006/0", ifidPc, ifidInstr, imemReq); end
    stall = 1'b0;
    #1;
    checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL st_skidfull: got req=%b need 0", imemReq); end
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidPc !== 16'h0008 || ifidInstr !== 16'h1008) begin errors++; $display("FAIL st_drain: got v=%b pc=%h instr=%h need 1/0008/1008", ifidValid, ifidPc, ifidInstr); end
    checks++; if (imemReq !== 1'b1 || imemAddr !== 16'h000A) begin errors++; $display("FAIL st_resume: got req=%b addr=%h need 1/000A", imemReq, imemAddr); end
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidPc !== 16'h000A) begin errors++; $display("FAIL st_next: got v=%b pc=%h need 1/000A", ifidValid, ifidPc); end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 5;
    tick();
    checks++; if (ifidValid !== 1'b0 || imemAddr !== 16'h000C || imemReq !== 1'b1) begin errors++; $display("FAIL rd_wait: got v=%b addr=%h req=%b need 0/000C/1", ifidValid, imemAddr, imemReq); end
    redirect = 1'b1; redirectPc = 16'h0041; force_rdy = 1'b1;
    tick();
    redirect = 1'b0; force_rdy = 1'b0; mem_lat = 0;
    #1;
    checks++; if (ifidValid !== 1'b0 || imemAddr !== 16'h0040 || imemReq !== 1'b1) begin errors++; $display("FAIL rd_flush: got v=%b addr=%h req=%b need 0/0040/1", ifidValid, imemAddr, imemReq); end
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidPc !== 16'h0040 || ifidInstr !== 16'h1040) begin errors++; $display("FAIL rd_target: got v=%b pc=%h instr=%h need 1/0040/1040", ifidValid, ifidPc, ifidInstr); end
  endtask

  task automatic test_halt();
    redirect = 1'b1; redirectPc = 16'h0010;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (imemAddr !== 16'h0010) begin errors++; $display("FAIL ht_addr: got %h need 0010", imemAddr); end
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidPc !== 16'h0010 || opcode !== 4'h0) begin errors++; $display("FAIL ht_enter: got v=%b pc=%h op=%h need 1/0010/0", ifidValid, ifidPc, opcode); end
    checks++; if (halted !== 1'b1 || imemReq !== 1'b0) begin errors++; $display("FAIL ht_state: got halted=%b req=%b need 1/0", halted, imemReq); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (halted !== 1'b1 || imemReq !== 1'b0 || ifidValid !== 1'b0) begin errors++; $display("FAIL ht_idle%0d: got halted=%b req=%b v=%b need 1/0/0", i, halted, imemReq, ifidValid); end
    end
    redirect = 1'b1; redirectPc = 16'h0020;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 16'h0020) begin errors++; $display("FAIL ht_exit: got halted=%b req=%b addr=%h need 0/1/0020", halted, imemReq, imemAddr); end
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidPc !== 16'h0020) begin errors++; $display("FAIL ht_resume: got v=%b pc=%h need 1/0020", ifidValid, ifidPc); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirectPc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (imemAddr !== 16'hFFFE) begin errors++; $display("FAIL wr_align: got %h need FFFE", imemAddr); end
    tick();
    checks++; if (ifidPc !== 16'hFFFE || ifidPcPlus2 !== 16'h0000 || ifidInstr !== 16'h1FFE) begin errors++; $display("FAIL wr_ifid: got pc=%h p2=%h instr=%h need FFFE/0000/1FFE", ifidPc, ifidPcPlus2, ifidInstr); end
    checks++; if (imemAddr !== 16'h0000) begin errors++; $display("FAIL wr_next: got %h need 0000", imemAddr); end
    tick();
    checks++; if (ifidPc !== 16'h0000 || ifidInstr !== 16'hF001) begin errors++; $display("FAIL wr_after: got pc=%h instr=%h need 0000/F001", ifidPc, ifidInstr); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect = 1'b1; redirectPc = 16'h0030;
    tick();
    stall = 1'b0; redirect = 1'b0;
    #1;
    checks++; if (ifidValid !== 1'b0 || imemAddr !== 16'h0030 || imemReq !== 1'b1) begin errors++; $display("FAIL sr_flush: got v=%b addr=%h req=%b need 0/0030/1", ifidValid, imemAddr, imemReq); end
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidPc !== 16'h0030) begin errors++; $display("FAIL sr_resume: got v=%b pc=%h need 1/0030", ifidValid, ifidPc); end
  endtask

  task automatic test_rst_mid_wait();
    mem_lat = 5;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL rm_reqdrop: got %b need 0", imemReq); end
    tick();
    checks++; if (ifidValid !== 1'b0 || ifidPc !== 16'h0000 || halted !== 1'b0) begin errors++; $display("FAIL rm_reset: got v=%b pc=%h halted=%b need 0/0000/0", ifidValid, ifidPc, halted); end
    rst = 1'b0; mem_lat = 0;
    #1;
    checks++; if (imemReq !== 1'b1 || imemAddr !== 16'h0000) begin errors++; $display("FAIL rm_restart: got req=%b addr=%h need 1/0000", imemReq, imemAddr); end
    tick();
    checks++; if (ifidValid !== 1'b1 || ifidInstr !== 16'hF001) begin errors++; $display("FAIL rm_first: got v=%b instr=%h need 1/F001", ifidValid, ifidInstr); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 16'h0000;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_wait();
    test_halt();
    test_wrap();
    test_stall_redirect();
    test_rst_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
